// File: rtl/pakout_arb2.sv
// Two-input round-robin arbiter sharing one 4-phase packet channel.
// One packet is captured per grant, then replayed downstream with a full handshake.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

module pakout_arb2_lane (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic set_i,
  input  logic clr_i,
  output logic ack_o
);
  logic ack_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    ack_q <= 1'b0;
    else if (set_i) ack_q <= 1'b1;
    else if (clr_i) ack_q <= 1'b0;
  end

  assign ack_o = ack_q;
endmodule

module pakout_arb2 #(
  parameter int ASZ = `NS_ADDRESS_SIZE,
  parameter int DSZ = `NS_DATA_SIZE,
  parameter int RSZ = `NS_REDUN_SIZE
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [ASZ-1:0] i0_src,
  input  logic [ASZ-1:0] i0_dst,
  input  logic [DSZ-1:0] i0_dat,
  input  logic [RSZ-1:0] i0_red,
  input  logic           i0_req,
  output logic           i0_ack,
  input  logic [ASZ-1:0] i1_src,
  input  logic [ASZ-1:0] i1_dst,
  input  logic [DSZ-1:0] i1_dat,
  input  logic [RSZ-1:0] i1_red,
  input  logic           i1_req,
  output logic           i1_ack,
  output logic [ASZ-1:0] o0_src,
  output logic [ASZ-1:0] o0_dst,
  output logic [DSZ-1:0] o0_dat,
  output logic [RSZ-1:0] o0_red,
  output logic           o0_req,
  input  logic           o0_ack,
  output logic           o_busy,
  output logic           o_grant
);
  localparam int NUM_LANES = 2;

  typedef struct packed {
    logic [ASZ-1:0] src;
    logic [ASZ-1:0] dst;
    logic [DSZ-1:0] dat;
    logic [RSZ-1:0] red;
  } pkt_t;

  typedef enum logic [2:0] {IDLE, CAPT, OWAIT, OREQ, OREL} state_t;

  state_t                state_q, state_d;
  pkt_t                  pkt_q, pkt_d;
  pkt_t [NUM_LANES-1:0]  in_pkt;
  logic [NUM_LANES-1:0]  req, ack, ack_set, ack_clr;
  logic                  grant_q, grant_d;
  logic                  oreq_q, oreq_d;
  logic                  busy_q, busy_d;
  logic                  gnt;

  assign in_pkt[0] = {i0_src, i0_dst, i0_dat, i0_red};
  assign in_pkt[1] = {i1_src, i1_dst, i1_dat, i1_red};
  assign req       = {i1_req, i0_req};

  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    grant_d = grant_q;
    oreq_d  = oreq_q;
    ack_set = '0;
    ack_clr = '0;
    gnt     = grant_q;
    case (state_q)
      IDLE: if (|req) begin
        // On contention the input not served last wins.
        gnt          = (&req) ? ~grant_q : req[1];
        grant_d      = gnt;
        pkt_d        = in_pkt[gnt];
        ack_set[gnt] = 1'b1;
        state_d      = CAPT;
      end
      CAPT: if (!req[grant_q]) begin
        ack_clr[grant_q] = 1'b1;
        if (!o0_ack) begin
          oreq_d  = 1'b1;
          state_d = OREQ;
        end else begin
          state_d = OWAIT;
        end
      end
      OWAIT: if (!o0_ack) begin
        oreq_d  = 1'b1;
        state_d = OREQ;
      end
      OREQ: if (o0_ack) begin
        oreq_d  = 1'b0;
        state_d = OREL;
      end
      OREL: if (!o0_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      pkt_q   <= '0;
      grant_q <= 1'b1;
      oreq_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      grant_q <= grant_d;
      oreq_q  <= oreq_d;
      busy_q  <= busy_d;
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    pakout_arb2_lane u_lane (
      .clk_i  (i_clk),
      .rst_ni (i_rst_n),
      .set_i  (ack_set[l]),
      .clr_i  (ack_clr[l]),
      .ack_o  (ack[l])
    );
  end

  assign i0_ack  = ack[0];
  assign i1_ack  = ack[1];
  assign o0_src  = pkt_q.src;
  assign o0_dst  = pkt_q.dst;
  assign o0_dat  = pkt_q.dat;
  assign o0_red  = pkt_q.red;
  assign o0_req  = oreq_q;
  assign o_busy  = busy_q;
  assign o_grant = grant_q;
endmodule

// File: tb/tb_pakout_arb2.sv
// Directed bench for pakout_arb2: handshake latency, arbitration order, stability, reset.
module tb_pakout_arb2;
  localparam int ASZ = 8, DSZ = 8, RSZ = 4;

  logic           i_clk = 1'b0;
  logic           i_rst_n;
  logic [ASZ-1:0] i0_src, i0_dst, i1_src, i1_dst, o0_src, o0_dst;
  logic [DSZ-1:0] i0_dat, i1_dat, o0_dat;
  logic [RSZ-1:0] i0_red, i1_red, o0_red;
  logic           i0_req, i1_req, i0_ack, i1_ack;
  logic           o0_req, o0_ack, o_busy, o_grant;

  logic resp_en, man_ack;
  logic resp_ack = 1'b0;
  logic req_seen = 1'b0;
  int   lg_g[$], lg_d[$];
  int   n_chk = 0, n_err = 0;
  int   base, cyc;

  pakout_arb2 #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i0_src(i0_src), .i0_dst(i0_dst), .i0_dat(i0_dat), .i0_red(i0_red),
    .i0_req(i0_req), .i0_ack(i0_ack),
    .i1_src(i1_src), .i1_dst(i1_dst), .i1_dat(i1_dat), .i1_red(i1_red),
    .i1_req(i1_req), .i1_ack(i1_ack),
    .o0_src(o0_src), .o0_dst(o0_dst), .o0_dat(o0_dat), .o0_red(o0_red),
    .o0_req(o0_req), .o0_ack(o0_ack),
    .o_busy(o_busy), .o_grant(o_grant)
  );

  always #5 i_clk = ~i_clk;

  assign o0_ack = resp_en ? resp_ack : man_ack;

  // 1-cycle responder plus a log of every packet offered on o0.
  always @(posedge i_clk) begin
    #2;
    resp_ack = o0_req;
    if (o0_req && !req_seen) begin
      lg_g.push_back(int'(o_grant));
      lg_d.push_back(int'(o0_dat));
    end
    req_seen = o0_req;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input int idx, input logic [7:0] s, input logic [7:0] d,
                      input logic [7:0] da, input logic [3:0] r);
    int n;
    if (idx == 0) begin i0_src = s; i0_dst = d; i0_dat = da; i0_red = r; i0_req = 1'b1; end
    else          begin i1_src = s; i1_dst = d; i1_dat = da; i1_red = r; i1_req = 1'b1; end
    for (n = 0; n < 60; n++) begin
      @(negedge i_clk);
      if ((idx == 0) ? i0_ack : i1_ack) break;
    end
    if (n >= 60) chk("ack_rise_timeout", 0, 1);
    if (idx == 0) i0_req = 1'b0; else i1_req = 1'b0;
    for (n = 0; n < 60; n++) begin
      @(negedge i_clk);
      if (!((idx == 0) ? i0_ack : i1_ack)) break;
    end
    if (n >= 60) chk("ack_fall_timeout", 0, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    for (n = 0; n < 100; n++) begin
      if (!o_busy) break;
      @(negedge i_clk);
    end
    chk(tag, o_busy, 0);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0; i0_req = 1'b0; i1_req = 1'b0; man_ack = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    i_rst_n = 1'b0; resp_en = 1'b1; man_ack = 1'b0;
    i0_src = '0; i0_dst = '0; i0_dat = '0; i0_red = '0; i0_req = 1'b0;
    i1_src = '0; i1_dst = '0; i1_dat = '0; i1_red = '0; i1_req = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;

    // Reset state
    chk("rst_i0_ack", i0_ack, 0);
    chk("rst_i1_ack", i1_ack, 0);
    chk("rst_o0_req", o0_req, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_grant", o_grant, 1);
    chk("rst_pkt", {o0_src, o0_dst, o0_dat, o0_red}, 0);

    // Single packet on i0
    @(negedge i_clk);
    i0_src = 8'd3; i0_dst = 8'd1; i0_dat = 8'd5; i0_red = 4'd15; i0_req = 1'b1;
    @(negedge i_clk);
    chk("t1_ack_lat", i0_ack, 1);
    chk("t1_grant", o_grant, 0);
    chk("t1_busy", o_busy, 1);
    i0_req = 1'b0;
    @(negedge i_clk);
    chk("t1_oreq", o0_req, 1);
    chk("t1_src", o0_src, 3);
    chk("t1_dst", o0_dst, 1);
    chk("t1_dat", o0_dat, 5);
    chk("t1_red", o0_red, 15);
    cyc = 2;
    while (o_busy && cyc < 20) begin @(negedge i_clk); cyc++; end
    chk("t1_idle_within5", (cyc <= 5), 1);

    // Simultaneous requests after reset: i0 first
    do_reset();
    base = lg_g.size();
    @(negedge i_clk);
    fork
      send(0, 8'd1, 8'd2, 8'd5, 4'd1);
      send(1, 8'd2, 8'd3, 8'd9, 4'd2);
    join
    wait_idle("t2_idle");
    chk("t2_count", lg_g.size() - base, 2);
    if (lg_g.size() >= base + 2) begin
      chk("t2_g0", lg_g[base], 0);
      chk("t2_d0", lg_d[base], 5);
      chk("t2_g1", lg_g[base+1], 1);
      chk("t2_d1", lg_d[base+1], 9);
    end

    // Continuous traffic: 8 packets per input, strictly alternating
    base = lg_g.size();
    @(negedge i_clk);
    fork
      begin for (int k = 0; k < 8; k++) send(0, 8'd0, 8'd0, 8'(k), 4'd0); end
      begin for (int k = 0; k < 8; k++) send(1, 8'd1, 8'd0, 8'(k), 4'd0); end
    join
    wait_idle("t3_idle");
    chk("t3_count", lg_g.size() - base, 16);
    if (lg_g.size() >= base + 16)
      for (int k = 0; k < 16; k++) begin
        chk($sformatf("t3_g%0d", k), lg_g[base+k], k % 2);
        chk($sformatf("t3_d%0d", k), lg_d[base+k], k / 2);
      end

    // o0_ack still high when the input handshake completes
    resp_en = 1'b0; man_ack = 1'b0;
    @(negedge i_clk);
    i0_dat = 8'd4; i0_req = 1'b1;
    @(negedge i_clk);
    chk("t4_ack", i0_ack, 1);
    i0_req = 1'b0; man_ack = 1'b1;
    @(negedge i_clk);
    chk("t4_owait_a", o0_req, 0);
    chk("t4_busy", o_busy, 1);
    @(negedge i_clk);
    chk("t4_owait_b", o0_req, 0);
    man_ack = 1'b0;
    @(negedge i_clk);
    chk("t4_oreq", o0_req, 1);
    resp_en = 1'b1;
    wait_idle("t4_idle");

    // Input data change after capture is ignored
    resp_en = 1'b0; man_ack = 1'b0;
    @(negedge i_clk);
    i1_dat = 8'd7; i1_req = 1'b1;
    @(negedge i_clk);
    chk("t5_ack", i1_ack, 1);
    i1_req = 1'b0;
    @(negedge i_clk);
    chk("t5_oreq", o0_req, 1);
    chk("t5_dat_a", o0_dat, 7);
    i1_dat = 8'd2;
    @(negedge i_clk);
    chk("t5_dat_b", o0_dat, 7);
    resp_en = 1'b1;
    wait_idle("t5_idle");
    chk("t5_dat_c", o0_dat, 7);
    chk("t5_grant", o_grant, 1);

    // Reset while in OREQ
    resp_en = 1'b0; man_ack = 1'b0;
    @(negedge i_clk);
    i0_dat = 8'd6; i0_req = 1'b1;
    @(negedge i_clk);
    i0_req = 1'b0;
    @(negedge i_clk);
    chk("t6_oreq", o0_req, 1);
    i1_req = 1'b1;
    i_rst_n = 1'b0;
    #1;
    chk("t6_rst_oreq", o0_req, 0);
    chk("t6_rst_i0ack", i0_ack, 0);
    chk("t6_rst_i1ack", i1_ack, 0);
    i1_req = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    chk("t6_busy", o_busy, 0);
    chk("t6_grant", o_grant, 1);
    chk("t6_dat", o0_dat, 0);
    resp_en = 1'b1;
    @(negedge i_clk);
    base = lg_g.size();
    fork
      send(0, 8'd0, 8'd0, 8'd11, 4'd0);
      send(1, 8'd0, 8'd0, 8'd12, 4'd0);
    join
    wait_idle("t6_idle");
    chk("t6_count", lg_g.size() - base, 2);
    if (lg_g.size() >= base + 2) begin
      chk("t6_g0", lg_g[base], 0);
      chk("t6_d0", lg_d[base], 11);
      chk("t6_d1", lg_d[base+1], 12);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
